comm_master: RTL and testbench
==============================

# comm_master

Host-side initiator for the logic-analyzer command protocol. It serializes a 16-bit command as two 8N1 UART bytes (high byte first) toward the command/config responder, then collects that responder's response bytes from an external UART receiver. For read, write and invalid opcodes it collects one byte; for a dump it collects exactly ENTRIES bytes. It then pulses completion. It sits in the bench/host model and in any on-chip master that drives the analyzer over its serial link.

## Interface
- BAUD_CNT, 16'd2604: clocks per UART bit.
- ENTRIES, 384: response bytes expected for a dump command.
- LOG2, 9: width of the dump byte counter.
- TIMEOUT_CYC, 32'd100000: idle cycles tolerated while waiting for one response byte (only with COMM_TIMEOUT_EN).
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd  in  16  command word: [15:14] opcode, [13:8] register/channel, [7:0] data.
- snd_cmd  in  1  one-cycle request to send cmd; sampled only in IDLE.
- TX  out  1  serial output, idle high.
- rx_rdy  in  1  external receiver holds a byte.
- rx_data  in  8  received byte.
- clr_rx_rdy  out  1  one-cycle pulse consuming the current rx byte.
- resp  out  8  last received response byte; holds until the next byte.
- resp_vld  out  1  one-cycle pulse coincident with resp update.
- cmd_cmplt  out  1  one-cycle pulse when the final expected byte is taken.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky timeout flag (constant 0 without the macro).

## Operation
- States: IDLE, TX_HIGH, TX_LOW, WAIT_RESP.
- IDLE: snd_cmd=1 latches cmd, loads the expected byte count, and goes to TX_HIGH.
  - Expected count is ENTRIES when opcode=2'b10 (Dump), else 1.
  - Opcode 2'b11 is sent unchanged; it expects 1 byte (responder NAK 8'hEE).
- TX_HIGH: transmits cmd[15:8]; on frame end goes to TX_LOW.
- TX_LOW: transmits cmd[7:0]; on frame end goes to WAIT_RESP.
- WAIT_RESP, per byte: rx_rdy=1 causes, on the same edge:
  - resp <= rx_data;
  - resp_vld and clr_rx_rdy pulse;
  - the remaining count decrements.
- WAIT_RESP, final byte: when the count reaches zero, cmd_cmplt pulses together with the last resp_vld and the state returns to IDLE.
- rx_rdy outside WAIT_RESP is ignored and not cleared.
- rx_rdy held high across consecutive cycles: one byte is taken per cycle the FSM sees it. The receiver must drop rx_rdy the cycle after clr_rx_rdy.
- snd_cmd while busy is ignored; no queueing.
- Frame format: start bit 0, data LSB first, stop bit 1, each bit BAUD_CNT clocks, 10*BAUD_CNT clocks per byte.
- Counter widths:
  - baud counter 16 bits;
  - bit counter 4 bits, 0..9;
  - byte counter LOG2 bits.
  - All compare on equality; no wrap occurs in legal operation.

## Timing
- snd_cmd sampled at edge N: TX low (start of high byte) from edge N+1.
- Low-byte start bit follows the high-byte stop bit with no idle gap. WAIT_RESP is entered at edge N+1+20*BAUD_CNT.
- Response latency: resp/resp_vld are valid the cycle after the edge that samples rx_rdy=1.
- Earliest next command: snd_cmd in the cycle after cmd_cmplt is accepted.
- Reset values: TX=1, resp=8'h00, resp_vld=0, clr_rx_rdy=0, cmd_cmplt=0, busy=0, timeout=0, state IDLE.
- Reset mid-frame:
  - TX returns high on the next edge;
  - counters clear;
  - no cmd_cmplt is produced.
- Simultaneous rx_rdy and last-bit frame end in TX_LOW: the rx byte is not taken that cycle. It is taken in the first WAIT_RESP cycle.

## Configuration
- Macro COMM_TIMEOUT_EN, defined:
  - a 32-bit counter runs in WAIT_RESP and clears on every accepted byte;
  - reaching TIMEOUT_CYC sets timeout, returns to IDLE and produces no cmd_cmplt;
  - timeout clears on reset or the next accepted snd_cmd.
- Macro COMM_TIMEOUT_EN, undefined:
  - no counter is built; WAIT_RESP waits indefinitely;
  - timeout is tied 0.

## Structure
- Package comm_pkg holds:
  - opcode enum {ReadReg=2'b00, WriteReg=2'b01, Dump=2'b10};
  - constants ACK=8'hA5 and NAK=8'hEE;
  - the FSM state enum.
- Sub-module uart_tx (clk, rst, trmt, tx_data, TX, tx_done) performs the 8N1 shift. comm_master sequences two trmt pulses and owns byte counting.

## Test plan
All scenarios use BAUD_CNT=4 and ENTRIES=8 for speed.
- Read: cmd=16'h0507, snd_cmd → TX frames 0x05 then 0x07 (40 clocks each) → bench rx_data=8'h3C → resp=8'h3C, resp_vld=1 and cmd_cmplt=1 in the same cycle, busy falls.
- Write: cmd=16'h41AB → frames 0x41, 0xAB; rx 8'hA5 → one resp_vld and cmd_cmplt, resp=8'hA5.
- Dump: cmd=16'h8100 → bytes 0x00..0x07 fed, 20 cycles apart → eight resp_vld pulses in order; cmd_cmplt only with the 8th.
- snd_cmd re-asserted in TX_LOW and rx_rdy asserted in TX_HIGH → both ignored: no extra frame, no clr_rx_rdy, resp stays 8'h00.
- rst asserted mid high-byte frame → TX=1 next cycle, busy=0; a new cmd then sends cleanly.
- With COMM_TIMEOUT_EN and TIMEOUT_CYC=50: Read command, no rx → timeout=1 after 50 WAIT_RESP cycles, busy=0, no cmd_cmplt.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared types and constants for the logic-analyzer command master.
package comm_pkg;

  typedef enum logic [1:0] {
    ReadReg  = 2'b00,
    WriteReg = 2'b01,
    Dump     = 2'b10
  } opcode_e;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TX_HIGH   = 2'd1,
    TX_LOW    = 2'd2,
    WAIT_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/comm_master_uart_tx.sv
// 8N1 serializer: start 0, data LSB first, stop 1, BAUD_CNT clocks per bit.
module uart_tx #(
  parameter logic [15:0] BAUD_CNT = 16'd2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  logic        active_q;
  logic [15:0] baud_q;
  logic [3:0]  bit_q;
  logic [8:0]  shift_q;
  logic        tx_q;
  logic        bit_end;

  assign bit_end = (baud_q == BAUD_CNT - 16'd1);
  // Raised during the last stop-bit clock so a follow-on frame starts with no gap.
  assign tx_done = active_q && bit_end && (bit_q == 4'd9);
  assign TX      = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else if (trmt) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, tx_data};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/comm_master.sv
// Command master: sends a 16-bit command as two UART bytes, then collects the
// response bytes. Optional response watchdog under `COMM_TIMEOUT_EN.
module comm_master #(
  parameter logic [15:0] BAUD_CNT    = 16'd2604,
  parameter int          ENTRIES     = 384,
  parameter int          LOG2        = 9,
  parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        cmd_cmplt,
  output logic        busy,
  output logic        timeout
);
  import comm_pkg::*;

  state_e          state_q, state_d;
  logic [7:0]      lo_q, resp_q;
  logic [LOG2-1:0] cnt_q;
  logic            vld_q, clr_q, cmplt_q;
  logic            trmt, tx_done, take, last, tmo_hit, accept;
  logic [7:0]      tx_byte;

  assign accept = (state_q == IDLE) && snd_cmd;
  assign take   = (state_q == WAIT_RESP) && rx_rdy;
  assign last   = (cnt_q == LOG2'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (snd_cmd) state_d = TX_HIGH;
      TX_HIGH:   if (tx_done) state_d = TX_LOW;
      TX_LOW:    if (tx_done) state_d = WAIT_RESP;
      WAIT_RESP: if ((take && last) || tmo_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // High byte goes straight from the cmd input so TX starts on the accept edge.
  always_comb begin
    trmt    = 1'b0;
    tx_byte = lo_q;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        trmt    = snd_cmd;
        tx_byte = cmd[15:8];
        busy    = 1'b0;
      end
      TX_HIGH: trmt = tx_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q    <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      clr_q   <= 1'b0;
      cmplt_q <= 1'b0;
    end else begin
      vld_q   <= take;
      clr_q   <= take;
      cmplt_q <= take && last;
      if (take) begin
        resp_q <= rx_data;
        cnt_q  <= cnt_q - LOG2'(1);
      end
      if (accept) begin
        lo_q  <= cmd[7:0];
        cnt_q <= (opcode_e'(cmd[15:14]) == Dump) ? LOG2'(ENTRIES) : LOG2'(1);
      end
    end
  end

`ifdef COMM_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        to_q;

  assign tmo_hit = (state_q == WAIT_RESP) && !rx_rdy && (tmo_q == TIMEOUT_CYC - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || (state_q != WAIT_RESP) || rx_rdy) tmo_q <= '0;
    else                                          tmo_q <= tmo_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || accept) to_q <= 1'b0;
    else if (tmo_hit)  to_q <= 1'b1;
  end

  assign timeout = to_q;
`else
  assign tmo_hit = 1'b0;
  // No watchdog in this build; the parameter is referenced only to keep it declared.
  assign timeout = 1'b0 & (TIMEOUT_CYC != 32'd0);
`endif

  uart_tx #(.BAUD_CNT(BAUD_CNT)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_byte),
    .TX      (TX),
    .tx_done (tx_done)
  );

  assign resp       = resp_q;
  assign resp_vld   = vld_q;
  assign clr_rx_rdy = clr_q;
  assign cmd_cmplt  = cmplt_q;

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master: cycle-level behavioural model + UART frame decoder,
// directed scenarios then randomized commands. Honors `COMM_TIMEOUT_EN.
module tb_comm_master;
  localparam int B   = 4;
  localparam int ENT = 8;
  localparam int TO  = 50;
  localparam int FR  = 20 * B;

  logic        clk = 1'b0, rst = 1'b1, snd_cmd = 1'b0, rx_rdy = 1'b0;
  logic [15:0] cmd = '0;
  logic [7:0]  rx_data = '0;
  logic        TX, clr_rx_rdy, resp_vld, cmd_cmplt, busy, timeout;
  logic [7:0]  resp;

  always #5 clk = ~clk;

  comm_master #(.BAUD_CNT(16'(B)), .ENTRIES(ENT), .LOG2(4), .TIMEOUT_CYC(32'(TO))) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd), .TX(TX),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .resp(resp), .resp_vld(resp_vld), .cmd_cmplt(cmd_cmplt),
    .busy(busy), .timeout(timeout)
  );

  int n_chk = 0, n_pass = 0;
  int n_cmplt = 0, n_vld = 0, n_clr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit         wave [0:FR-1];
  int         tx_left = 0, tx_idx = 0, rem = 0, wcnt = 0;
  logic       e_tx = 1'b1, e_vld = 1'b0, e_clr = 1'b0, e_cmplt = 1'b0, e_to = 1'b0;
  logic [7:0] e_resp = '0;

  always @(posedge clk) begin : model
    logic [7:0] by;
    int j;
    #1;
    e_vld = 1'b0; e_clr = 1'b0; e_cmplt = 1'b0;
    if (rst) begin
      tx_left = 0; rem = 0; wcnt = 0; e_tx = 1'b1; e_resp = '0; e_to = 1'b0;
    end else if (tx_left == 0 && rem == 0) begin
      if (snd_cmd) begin
        for (int k = 0; k < 20; k++) begin
          by = (k < 10) ? cmd[15:8] : cmd[7:0];
          j  = k % 10;
          for (int r = 0; r < B; r++)
            wave[k*B + r] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : by[j-1];
        end
        tx_left = FR; tx_idx = 1; e_tx = wave[0];
        rem = (cmd[15:14] == 2'b10) ? ENT : 1;
        wcnt = 0; e_to = 1'b0;
      end
    end else if (tx_left > 0) begin
      tx_left--;
      e_tx = (tx_idx < FR) ? wave[tx_idx] : 1'b1;
      tx_idx++;
    end else begin
      if (rx_rdy) begin
        e_resp = rx_data; e_vld = 1'b1; e_clr = 1'b1; rem--; wcnt = 0;
        if (rem == 0) e_cmplt = 1'b1;
      end else begin
        wcnt++;
`ifdef COMM_TIMEOUT_EN
        if (wcnt == TO) begin e_to = 1'b1; rem = 0; end
`endif
      end
    end
    chk("TX", TX, e_tx);
    chk("busy", busy, (tx_left > 0 || rem > 0));
    chk("resp", resp, e_resp);
    chk("resp_vld", resp_vld, e_vld);
    chk("clr_rx_rdy", clr_rx_rdy, e_clr);
    chk("cmd_cmplt", cmd_cmplt, e_cmplt);
    chk("timeout", timeout, e_to);
    if (cmd_cmplt === 1'b1)  n_cmplt++;
    if (resp_vld === 1'b1)   n_vld++;
    if (clr_rx_rdy === 1'b1) n_clr++;
  end

  // ---------------- UART frame decoder ----------------
  logic [7:0] frames [$];
  logic       dact = 1'b0;
  int         ph = 0;
  logic [7:0] dbyte = '0;

  always @(posedge clk) begin : decoder
    int k;
    #2;
    if (rst) dact = 1'b0;
    else if (!dact) begin
      if (TX == 1'b0) begin dact = 1'b1; ph = 0; end
    end else begin
      ph++;
      k = ph / B;
      if (ph % B == B / 2) begin
        if (k >= 1 && k <= 8) dbyte[k-1] = TX;
        if (k == 9) begin
          if (TX == 1'b1) frames.push_back(dbyte);
          dact = 1'b0;
        end
      end
    end
  end

  // ---------------- drivers (called at a negedge) ----------------
  task automatic send(input logic [15:0] c);
    cmd = c; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0; cmd = 16'($urandom);
  endtask

  task automatic give(input logic [7:0] d);
    int t;
    rx_data = d; rx_rdy = 1'b1;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (clr_rx_rdy) break;
    end
    rx_rdy = 1'b0;
    if (t == 400) chk("rx_taken", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, v0, l0, j;
    logic [1:0]  op;
    logic [15:0] c;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_TX", TX, 1); chk("rst_resp", resp, 8'h00); chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Read
    frames.delete();
    send(16'h0507);
    repeat (10) @(negedge clk);
    give(8'h3C);
    chk("read_resp", resp, 8'h3C); chk("read_vld", resp_vld, 1);
    chk("read_cmplt", cmd_cmplt, 1); chk("read_busy", busy, 0);
    chk("read_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("read_hi", frames[0], 8'h05); chk("read_lo", frames[1], 8'h07);
    end

    // Write
    frames.delete();
    send(16'h41AB);
    give(8'hA5);
    chk("write_resp", resp, 8'hA5); chk("write_cmplt", cmd_cmplt, 1);
    chk("write_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("write_hi", frames[0], 8'h41); chk("write_lo", frames[1], 8'hAB);
    end

    // Dump
    c0 = n_cmplt; v0 = n_vld;
    send(16'h8100);
    for (int i = 0; i < ENT; i++) begin
      repeat (20) @(negedge clk);
      chk("dump_no_early_cmplt", n_cmplt - c0, 0);
      give(8'(i));
    end
    chk("dump_last_resp", resp, 8'h07); chk("dump_cmplt", cmd_cmplt, 1);
    chk("dump_vld_cnt", n_vld - v0, ENT); chk("dump_cmplt_cnt", n_cmplt - c0, 1);

    // Ignored snd_cmd in TX_LOW, rx_rdy from TX_HIGH held through frame end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    frames.delete(); l0 = n_clr;
    send(16'h0001);                         // now at j=1
    repeat (4) @(negedge clk);              // j=5, TX_HIGH
    rx_data = 8'h99; rx_rdy = 1'b1;
    repeat (45) @(negedge clk);             // j=50, TX_LOW
    cmd = 16'hFFFF; snd_cmd = 1'b1;
    @(negedge clk); snd_cmd = 1'b0;         // j=51
    repeat (27) @(negedge clk);             // j=78
    chk("ign_resp", resp, 8'h00); chk("ign_clr", n_clr - l0, 0);
    j = 78;
    while (!clr_rx_rdy && j < 120) begin @(negedge clk); j++; end
    rx_rdy = 1'b0;
    chk("ign_take_cycle", j, FR + 2);
    chk("ign_resp_taken", resp, 8'h99); chk("ign_cmplt", cmd_cmplt, 1);
    chk("ign_nframes", frames.size(), 2);

    // Reset mid high-byte frame
    send(16'h0507);
    repeat (10) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    chk("midrst_TX", TX, 1); chk("midrst_busy", busy, 0);
    rst = 1'b0; @(negedge clk);
    frames.delete();
    send(16'h41AB);
    give(8'h5A);
    chk("postrst_resp", resp, 8'h5A);
    chk("postrst_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("postrst_hi", frames[0], 8'h41); chk("postrst_lo", frames[1], 8'hAB);
    end

`ifdef COMM_TIMEOUT_EN
    c0 = n_cmplt;
    send(16'h0011);                         // j=1
    j = 1;
    while (busy && j < 400) begin @(negedge clk); j++; end
    chk("to_release_cycle", j, FR + TO + 1);
    chk("to_flag", timeout, 1); chk("to_no_cmplt", n_cmplt - c0, 0);
    send(16'h0022);
    chk("to_cleared", timeout, 0);
    give(8'h11);
`endif

    // Randomized commands, back-to-back, with spurious snd_cmd while busy
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      c  = {op, 14'($urandom)};
      n  = (op == 2'b10) ? ENT : 1;
      send(c);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        cmd = 16'($urandom); snd_cmd = 1'b1;
        @(negedge clk); snd_cmd = 1'b0;
      end
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, (n > 1) ? 10 : 30)) @(negedge clk);
        give(8'($urandom));
      end
      chk("rand_idle", busy, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
